serial_tx: RTL
==============

Name: serial_tx

Overview:
Framed serial transmitter and the driving end of a single-bit serial link. A DFF-based serial receiver on the far end samples this line.
- Accepts a parallel word via a valid/ready handshake.
- Shifts the word out LSB-first on a one-wire line with start bit, optional even parity and stop bit.
- Each bit is held for a programmable number of clock cycles.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DIV, 4, clock cycles per serial bit (>=1)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
ck  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
data_in  input  WIDTH  word to transmit, sampled on accept
valid  input  1  data_in is offered
ready  output  1  block can accept a word (high only in IDLE)
txd  output  1  serial line, idle high, registered
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse: frame's stop bit completed

Behaviour:
- Reset (async, rst=1): state=IDLE, txd=1, busy=0, ready=1, done=0. Shift register, bit counter and tick counter are cleared.
- Reset mid-frame: txd returns to 1 immediately. The frame is abandoned and no done pulse is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: at a rising edge with valid=1 and ready=1.
  - data_in is latched into the shift register.
  - Parity is computed as the XOR of data_in.
  - State goes to START; txd=0 from the next cycle.
  - valid while busy is ignored and data_in is not sampled.
- Bit timing: a tick counter runs 0..DIV-1 within each bit. The bit ends at the edge where the count = DIV-1. Every bit, including start and stop, lasts exactly DIV cycles. With DIV=1 the counter is constant and each bit lasts one cycle.
- START -> DATA: at the end of the start bit.
  - txd = shift[0]; the shift register moves right once per bit end.
  - The bit index counts 0..WIDTH-1.
- DATA -> PARITY when PARITY_EN=1, else DATA -> STOP, after bit WIDTH-1. In PARITY, txd = latched parity (even: total number of ones in data plus parity is even).
- STOP: txd=1 for DIV cycles. At its final edge: state=IDLE, done=1 for exactly one cycle, ready=1.
- Back-to-back: if valid=1 in the first IDLE cycle (the done cycle), the word is accepted at that edge.
  - Minimum inter-frame idle is 1 cycle of txd=1.
  - Frame length = (2 + WIDTH + PARITY_EN) * DIV cycles from the first cycle of txd=0 to the last stop cycle.
- Width rules:
  - tick counter = clog2(DIV), minimum 1 bit.
  - bit index = clog2(WIDTH), minimum 1 bit.
  - No arithmetic overflow is possible; counters are compared against DIV-1 and WIDTH-1.
- ready and busy decode combinationally from the state register; ready = ~busy. txd and done are registered.

Decomposition:
- Package serial_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the constants LINE_IDLE=1'b1, START_LVL=1'b0 and STOP_LVL=1'b1.
- One sub-module, bit_timer:
  - parameter DIV; inputs ck, rst, run;
  - output bit_end, a one-cycle pulse every DIV cycles while run=1;
  - the counter clears when run=0.
- The FSM, shift register and parity logic stay in serial_tx.

Test Plan:
- WIDTH=8, DIV=4, PARITY_EN=1; send 0xA5 -> txd over 44 cycles reads 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles. Parity bit is 0 (4 ones). done pulses once after the stop bit; ready low for the whole 44 cycles.
- Send 0x07 with parity -> parity bit 1 (3 ones). With PARITY_EN=0 the frame is 40 cycles and there is no parity slot.
- Hold valid high with 0x3C then 0xC3 -> 0xC3 is accepted in the done cycle. There is exactly 1 idle-high cycle between frames, and both frames decode correctly.
- Pulse valid with 0xFF mid-frame while busy -> ignored. The current frame's bits are unchanged and no second frame follows.
- Assert rst asynchronously during DATA bit 3 -> txd=1, busy=0, ready=1 within the same cycle, and no done pulse. A new word sent after release transmits normally.
- DIV=1, WIDTH=4, PARITY_EN=1; send 0x9 -> txd sequence 0,1,0,0,1,0,1 over 7 consecutive cycles, then done.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and line levels for the framed serial transmitter.
//   tx_state_t        : frame FSM states
//   LINE_IDLE/START_LVL/STOP_LVL : txd levels for idle line, start bit, stop bit
package serial_tx_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: valid/ready word handshake into the serial transmitter.
//   data_in : word to transmit (sampled on accept)
//   valid   : data_in is offered
//   ready   : transmitter can accept a word
interface serial_tx_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] data_in;
   logic             valid;
   logic             ready;

   modport master (output data_in, valid, input ready);
   modport slave  (input data_in, valid, output ready);
endinterface

// File: rtl/bit_timer.sv
// bit_timer: per-bit tick counter for the serial transmitter.
//   ck, rst : clock, async active-high reset
//   run     : count while high; counter held at zero while low
//   bit_end : one-cycle pulse on the last cycle of each DIV-cycle bit
module bit_timer #(
   parameter int DIV = 4
) (
   input  logic ck,
   input  logic rst,
   input  logic run,
   output logic bit_end
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // With DIV=1 LAST is zero, the counter never leaves zero and every run cycle is a bit end.
   assign bit_end = run && (cnt == LAST);

   always_ff @(posedge ck or posedge rst) begin
      if (rst)                     cnt <= '0;
      else if (!run || cnt == LAST) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: framed serial transmitter (start, WIDTH data bits LSB-first,
// optional even parity, stop), each bit held DIV clock cycles.
//   ck, rst : clock, async active-high reset
//   bus     : valid/ready word handshake (slave side); ready high only in IDLE
//   txd     : registered serial line, idle high
//   busy    : frame in progress
//   done    : one-cycle pulse after the stop bit completes
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIV       = 4,
   parameter int PARITY_EN = 1
) (
   input  logic        ck,
   input  logic        rst,
   serial_tx_if.slave  bus,
   output logic        txd,
   output logic        busy,
   output logic        done
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   tx_state_t        state, state_n;
   logic [WIDTH-1:0] shift, shift_n;
   logic [IW-1:0]    idx, idx_n;
   logic             par, par_n;
   logic             txd_n, done_n;
   logic             bit_end;

   bit_timer #(.DIV(DIV)) u_timer (
      .ck      (ck),
      .rst     (rst),
      .run     (busy),
      .bit_end (bit_end)
   );

   assign bus.ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         shift <= '0;
         idx   <= '0;
         par   <= 1'b0;
         txd   <= LINE_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         shift <= shift_n;
         idx   <= idx_n;
         par   <= par_n;
         txd   <= txd_n;
         done  <= done_n;
      end
   end

   // txd is registered, so each branch computes the level for the bit that
   // starts on the next cycle, and the shift register advances as its LSB goes out.
   always_comb begin
      state_n = state;
      shift_n = shift;
      idx_n   = idx;
      par_n   = par;
      txd_n   = txd;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            txd_n = LINE_IDLE;
            if (bus.valid) begin
               state_n = START;
               shift_n = bus.data_in;
               par_n   = ^bus.data_in;
               idx_n   = '0;
               txd_n   = START_LVL;
            end
         end
         START: if (bit_end) begin
            state_n = DATA;
            txd_n   = shift[0];
            shift_n = shift >> 1;
         end
         DATA: if (bit_end) begin
            if (idx == LAST_IDX) begin
               if (PARITY_EN != 0) begin
                  state_n = PARITY;
                  txd_n   = par;
               end else begin
                  state_n = STOP;
                  txd_n   = STOP_LVL;
               end
            end else begin
               idx_n   = idx + IW'(1);
               txd_n   = shift[0];
               shift_n = shift >> 1;
            end
         end
         PARITY: if (bit_end) begin
            state_n = STOP;
            txd_n   = STOP_LVL;
         end
         STOP: if (bit_end) begin
            state_n = IDLE;
            txd_n   = LINE_IDLE;
            done_n  = 1'b1;
         end
         default: begin
            state_n = IDLE;
            txd_n   = LINE_IDLE;
         end
      endcase
   end
endmodule
